// File: rtl/set_pkg.sv
// Shared definitions for the SET engine host: mode/error encodings, FSM states, operand field layout.
package set_pkg;

  localparam int COORD_W   = 4;
  localparam int RAD_W     = 4;
  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int MODE_W    = 2;
  localparam int COUNT_W   = 8;
  localparam int JOB_W     = CENTRAL_W + RADIUS_W + MODE_W;

  // central = {x1, y1, x2, y2, 8'h00}; radius = {r1, r2, 4'h0}
  localparam int X1_LSB = 20;
  localparam int Y1_LSB = 16;
  localparam int X2_LSB = 12;
  localparam int Y2_LSB = 8;
  localparam int R1_LSB = 8;
  localparam int R2_LSB = 4;

  typedef enum logic [1:0] {
    MODE_A       = 2'd0,
    MODE_AND     = 2'd1,
    MODE_XOR     = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_MODE    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    logic [MODE_W-1:0]    mode;
  } job_t;

endpackage

// File: rtl/set_host_fifo.sv
// Synchronous FIFO holding queued jobs; push is ignored when full, pop is ignored when empty.
module set_host_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/set_host.sv
// Host for the SET engine: queues jobs, issues them one at a time, returns count/error results.
// Optional macro SET_HOST_TIMEOUT_EN aborts a job when the engine stays silent for TIMEOUT cycles.
module set_host
  import set_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CENTRAL_W-1:0] req_central,
  input  logic [RADIUS_W-1:0]  req_radius,
  input  logic [MODE_W-1:0]    req_mode,
  output logic                 en,
  output logic [CENTRAL_W-1:0] central,
  output logic [RADIUS_W-1:0]  radius,
  output logic [MODE_W-1:0]    mode,
  input  logic                 busy,
  input  logic                 valid,
  input  logic [COUNT_W-1:0]   candidate,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [COUNT_W-1:0]   res_count,
  output logic [1:0]           res_err,
  output logic [15:0]          jobs_done
);

  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("set_host: DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("set_host: TIMEOUT must be at least 2");
  end

  state_e state;
  state_e next_state;
  job_t   in_job;
  job_t   head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   timed_out;
  logic   unused_busy;

  assign unused_busy = busy;
  assign in_job      = '{central: req_central, radius: req_radius, mode: req_mode};
  assign req_ready   = !fifo_full;
  assign res_valid   = (state == ST_RESULT);

  set_host_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (JOB_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid && req_ready),
    .push_data (in_job),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef SET_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  // tcnt equals the number of cycles elapsed since the en cycle.
  assign timed_out = (state == ST_RUN) && !valid && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state == ST_ISSUE) begin
      tcnt <= TW'(1);
    end else if (state == ST_RUN) begin
      tcnt <= tcnt + TW'(1);
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    en         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !res_valid) begin
          pop        = 1'b1;
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mode == MODE_ILLEGAL) begin
          next_state = ST_RESULT;
        end else begin
          en         = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (valid || timed_out) next_state = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operands change only on pop, so they stay stable from en until the engine answers.
  always_ff @(posedge clk) begin
    if (rst) begin
      central   <= '0;
      radius    <= '0;
      mode      <= '0;
      res_count <= '0;
      res_err   <= ERR_OK;
      jobs_done <= '0;
    end else begin
      if (pop) begin
        central <= head.central;
        radius  <= head.radius;
        mode    <= head.mode;
      end
      if ((state == ST_ISSUE) && (mode == MODE_ILLEGAL)) begin
        res_count <= '0;
        res_err   <= ERR_MODE;
      end else if ((state == ST_RUN) && valid) begin
        res_count <= candidate;
        res_err   <= ERR_OK;
      end else if (timed_out) begin
        res_count <= '0;
        res_err   <= ERR_TIMEOUT;
      end
      if ((state == ST_RESULT) && res_ready) jobs_done <= jobs_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_set_host.sv
// Directed bench for set_host with a behavioural SET engine stub and an in-order result scoreboard.
module tb_set_host;
  import set_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_central;
  logic [11:0] req_radius;
  logic [1:0]  req_mode;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy;
  logic        valid;
  logic [7:0]  candidate;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_count;
  logic [1:0]  res_err;
  logic [15:0] jobs_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int  eng_lat  = 67;
  bit  stall    = 0;
  int  spur_req = 0;

  int  en_cnt        = 0;
  int  last_valid_cyc = -1;
  int  last_en_cyc   = 0;
  int  done_model    = 0;
  int  exp_cnt_q[$];
  int  exp_err_q[$];

  set_host #(
    .DEPTH   (4),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_central (req_central),
    .req_radius  (req_radius),
    .req_mode    (req_mode),
    .en          (en),
    .central     (central),
    .radius      (radius),
    .mode        (mode),
    .busy        (busy),
    .valid       (valid),
    .candidate   (candidate),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_count   (res_count),
    .res_err     (res_err),
    .jobs_done   (jobs_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Points (x,y) of an 8x8 grid lying inside circle A and/or circle B.
  function automatic logic [7:0] set_model(input logic [23:0] c, input logic [11:0] r,
                                           input logic [1:0] m);
    int x1, y1, x2, y2, r1, r2, n;
    bit ina, inb;
    x1 = int'(c[X1_LSB +: COORD_W]);
    y1 = int'(c[Y1_LSB +: COORD_W]);
    x2 = int'(c[X2_LSB +: COORD_W]);
    y2 = int'(c[Y2_LSB +: COORD_W]);
    r1 = int'(r[R1_LSB +: RAD_W]);
    r2 = int'(r[R2_LSB +: RAD_W]);
    n  = 0;
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        ina = ((x - x1) * (x - x1) + (y - y1) * (y - y1)) <= r1 * r1;
        inb = ((x - x2) * (x - x2) + (y - y2) * (y - y2)) <= r2 * r2;
        case (m)
          2'd0: if (ina) n++;
          2'd1: if (ina && inb) n++;
          2'd2: if (ina ^ inb) n++;
          default: ;
        endcase
      end
    end
    return 8'(n);
  endfunction

  // Engine stub: answers eng_lat cycles after en; stall freezes the countdown.
  initial begin
    int         eng_cnt;
    int         spur_seen;
    bit         nxt_valid;
    logic [7:0] eng_res;
    eng_cnt   = 0;
    spur_seen = 0;
    eng_res   = 0;
    valid     = 0;
    busy      = 0;
    candidate = 0;
    forever begin
      @(negedge clk);
      nxt_valid = 0;
      if (rst) begin
        eng_cnt = 0;
      end else if (eng_cnt != 0) begin
        if (!stall) begin
          eng_cnt--;
          if (eng_cnt == 0) nxt_valid = 1;
        end
      end else if (en) begin
        eng_res = set_model(central, radius, mode);
        eng_cnt = eng_lat - 1;
      end else if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        eng_res   = 8'h5A;
        nxt_valid = 1;
      end
      @(posedge clk);
      #1;
      valid     = nxt_valid;
      candidate = nxt_valid ? eng_res : 8'h00;
      busy      = (eng_cnt != 0);
    end
  end

  // Monitor: en spacing, operand hold, in-order result scoreboard.
  initial begin
    logic        prev_en;
    bit          op_pending;
    logic [37:0] op_at_en;
    int          ec, ee;
    prev_en    = 0;
    op_pending = 0;
    op_at_en   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        op_pending = 0;
        done_model = 0;
      end else begin
        if (en) begin
          en_cnt++;
          chk("en_gap", 64'((cyc > last_valid_cyc) && !prev_en), 64'd1);
          op_at_en    = {central, radius, mode};
          op_pending  = 1;
          last_en_cyc = cyc;
        end
        if (valid) begin
          if (op_pending) chk("op_hold", {central, radius, mode}, op_at_en);
          op_pending     = 0;
          last_valid_cyc = cyc;
        end
        if (res_valid && res_ready) begin
          if (exp_cnt_q.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
          end else begin
            ec = exp_cnt_q.pop_front();
            ee = exp_err_q.pop_front();
            chk("res_count", res_count, 64'(ec));
            chk("res_err", res_err, 64'(ee));
            chk("jobs_done_pre", jobs_done, 64'(done_model));
            done_model++;
          end
        end
      end
      prev_en = en;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input int c, input int e);
    exp_cnt_q.push_back(c);
    exp_err_q.push_back(e);
  endtask

  task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int waited;
    req_central = c;
    req_radius  = r;
    req_mode    = m;
    req_valid   = 1;
    waited      = 0;
    while (!req_ready && waited < 300) begin
      tick();
      waited++;
    end
    if (waited >= 300) chk("push_timeout", 64'd0, 64'd1);
    tick();
    req_valid = 0;
  endtask

  task automatic drain(input int max_cyc);
    int waited;
    waited = 0;
    while ((exp_cnt_q.size() != 0 || res_valid) && waited < max_cyc) begin
      tick();
      waited++;
    end
    if (waited >= max_cyc) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"}, req_ready, 64'd1);
    chk({pfx, "_en"},        en,        64'd0);
    chk({pfx, "_central"},   central,   64'd0);
    chk({pfx, "_radius"},    radius,    64'd0);
    chk({pfx, "_mode"},      mode,      64'd0);
    chk({pfx, "_res_valid"}, res_valid, 64'd0);
    chk({pfx, "_res_count"}, res_count, 64'd0);
    chk({pfx, "_res_err"},   res_err,   64'd0);
    chk({pfx, "_jobs_done"}, jobs_done, 64'd0);
  endtask

  initial begin
    int base;
    int waited;
    rst         = 1;
    req_valid   = 0;
    req_central = 0;
    req_radius  = 0;
    req_mode    = 0;
    res_ready   = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check_reset_outputs("reset");

    // Single nominal-latency job: circle (4,4) r3 covers 29 grid points.
    res_ready = 1;
    eng_lat   = 67;
    base      = en_cnt;
    expect_res(29, 0);
    push_job(24'h44_66_00, 12'h32_0, 2'd0);
    drain(300);
    chk("single_en_pulses", en_cnt - base, 64'd1);
    chk("single_jobs_done", jobs_done, 64'd1);

    // Four back-to-back jobs: A, A and B, A xor B, point circle at origin.
    eng_lat = 5;
    base    = en_cnt;
    expect_res(29, 0);
    expect_res(6, 0);
    expect_res(28, 0);
    expect_res(1, 0);
    push_job(24'h44_66_00, 12'h32_0, 2'd0);
    push_job(24'h44_66_00, 12'h32_0, 2'd1);
    push_job(24'h44_66_00, 12'h32_0, 2'd2);
    push_job(24'h00_00_00, 12'h00_0, 2'd0);
    drain(300);
    chk("b2b_en_pulses", en_cnt - base, 64'd4);
    chk("b2b_jobs_done", jobs_done, 64'd5);

    // Illegal mode never reaches the engine.
    base = en_cnt;
    expect_res(0, 1);
    push_job(24'h44_66_00, 12'h32_0, 2'd3);
    drain(100);
    chk("illegal_no_en", en_cnt - base, 64'd0);
    chk("illegal_jobs_done", jobs_done, 64'd6);

    // Result held under backpressure; queued job waits for the handshake.
    res_ready = 0;
    base      = en_cnt;
    expect_res(3, 0);
    expect_res(6, 0);
    push_job(24'h00_00_00, 12'h10_0, 2'd0);
    push_job(24'h00_00_00, 12'h20_0, 2'd0);
    waited = 0;
    while (!res_valid && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) chk("bp_wait_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_res_valid", res_valid, 64'd1);
      chk("bp_res_count", res_count, 64'd3);
      tick();
    end
    chk("bp_no_new_en", en_cnt - base, 64'd1);
    res_ready = 1;
    drain(100);
    chk("bp_jobs_done", jobs_done, 64'd8);

    // Fill the FIFO behind a stalled job.
    eng_lat = 4;
    stall   = 1;
    expect_res(29, 0);
    push_job(24'h44_66_00, 12'h32_0, 2'd0);
    repeat (4) tick();
    expect_res(1, 0);
    expect_res(3, 0);
    expect_res(6, 0);
    expect_res(11, 0);
    expect_res(17, 0);
    push_job(24'h00_00_00, 12'h00_0, 2'd0);
    push_job(24'h00_00_00, 12'h10_0, 2'd0);
    push_job(24'h00_00_00, 12'h20_0, 2'd0);
    push_job(24'h00_00_00, 12'h30_0, 2'd0);
    chk("full_ready_low", req_ready, 64'd0);
    req_central = 24'h00_00_00;
    req_radius  = 12'h40_0;
    req_mode    = 2'd0;
    req_valid   = 1;
    repeat (5) tick();
    chk("full_ready_held", req_ready, 64'd0);
    stall  = 0;
    waited = 0;
    while (!req_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) chk("full_pop_timeout", 64'd0, 64'd1);
    tick();
    req_valid = 0;
    drain(300);
    chk("fill_jobs_done", jobs_done, 64'd14);

    // Stray engine strobe while idle is ignored.
    spur_req++;
    repeat (5) tick();
    chk("spur_res_valid", res_valid, 64'd0);
    chk("spur_jobs_done", jobs_done, 64'd14);

    // Reset while RUN drops the job.
    stall = 1;
    base  = en_cnt;
    push_job(24'h44_66_00, 12'h32_0, 2'd1);
    repeat (3) tick();
    chk("midrun_en_seen", en_cnt - base, 64'd1);
    rst = 1;
    tick();
    check_reset_outputs("midrun_rst");
    rst   = 0;
    stall = 0;
    repeat (20) tick();
    chk("midrun_no_result", res_valid, 64'd0);

`ifdef SET_HOST_TIMEOUT_EN
    stall = 1;
    expect_res(0, 2);
    push_job(24'h44_66_00, 12'h32_0, 2'd0);
    waited = 0;
    while (!res_valid && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) chk("timeout_wait", 64'd0, 64'd1);
    chk("timeout_latency", 64'(cyc - last_en_cyc), 64'd16);
    chk("timeout_err", res_err, 64'd2);
    stall = 0;
    drain(100);
    repeat (10) tick();
    chk("timeout_jobs_done", jobs_done, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/set_host.md
SET_HOST -- requirements
Module: set_host

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 128, max cycles from engine en to engine valid before abort.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  job offered upstream.
REQ-006 req_ready  out  1  job accepted when req_valid && req_ready.
REQ-007 req_central  in  24  {x1,y1,x2,y2,8'h00}, 4-bit coordinates.
REQ-008 req_radius  in  12  {r1,r2,4'h0}.
REQ-009 req_mode  in  2  0=A, 1=A and B, 2=A xor B, 3=illegal.
REQ-010 en  out  1  one-cycle job start to SET engine.
REQ-011 central, radius, mode  out  24/12/2  engine operands.
REQ-012 busy, valid  in  1 each  engine status; valid is a one-cycle result strobe.
REQ-013 candidate  in  8  engine count, sampled only with valid.
REQ-014 res_valid  out  1  result available.
REQ-015 res_ready  in  1  result consumed when res_valid && res_ready.
REQ-016 res_count  out  8  point count (0..64).
REQ-017 res_err  out  2  0=ok, 1=illegal mode, 2=timeout.
REQ-018 jobs_done  out  16  completed results delivered, wraps at 16'hFFFF->0.

Function
REQ-019 Accepted jobs SHALL enter a DEPTH-entry FIFO in order; req_ready = !fifo_full.
REQ-020 Accept and pop in the same cycle when full SHALL be allowed only if pop occurs; req_ready stays combinationally tied to fifo_full (no bypass).
REQ-021 FSM states: IDLE, ISSUE, RUN, RESULT.
REQ-022 IDLE -> ISSUE when FIFO non-empty and res_valid == 0; pops head into operand registers.
REQ-023 ISSUE: if mode == 3, SHALL skip engine, load res_count=0, res_err=1, go RESULT; else assert en for exactly one cycle, go RUN.
REQ-024 central/radius/mode outputs SHALL hold stable from the en cycle until valid is seen (engine reads mode every compare cycle).
REQ-025 RUN: on valid, capture candidate into res_count, res_err=0, go RESULT.
REQ-026 RESULT: res_valid=1 until res_ready; on handshake jobs_done += 1, go IDLE.
REQ-027 Minimum gap: en SHALL NOT be reasserted earlier than the cycle after the prior valid.
REQ-028 Valid arriving in IDLE/ISSUE/RESULT SHALL be ignored.
REQ-029 Nominal engine latency 67 cycles en->valid; host imposes no fixed latency.

Reset
REQ-030 On rst: FSM=IDLE, FIFO empty, en=0, central=0, radius=0, mode=0, res_valid=0, res_count=0, res_err=0, jobs_done=0, timeout counter=0.
REQ-031 rst mid-RUN SHALL drop the in-flight job with no result; engine is reset by the same rst.

Configuration
REQ-032 Macro SET_HOST_TIMEOUT_EN: defined -> RUN counts cycles; at TIMEOUT with no valid, res_count=0, res_err=2, go RESULT; a late valid is ignored per REQ-028.
REQ-033 Undefined -> no counter; RUN waits indefinitely; res_err never 2.

Structure
REQ-034 Shared package set_pkg: mode encodings, err codes, FSM state enum, coordinate/radius field widths and slice positions.
REQ-035 One sub-module set_host_fifo (synchronous FIFO, DEPTH, width 38).

Verification
REQ-036 Job central=24'h44_66_00, radius=12'h32_0, mode=0 with SET model -> one en pulse, res_count per model, res_err=0, jobs_done=1.
REQ-037 Four back-to-back jobs with res_ready=1 -> results in order; en pulses never closer than valid+1.
REQ-038 Fill FIFO (DEPTH+1 offers, engine stalled) -> req_ready=0 after DEPTH accepts; extra job accepted after first pop.
REQ-039 mode=3 job -> no en, res_count=0, res_err=1 next result.
REQ-040 res_ready held low 10 cycles -> res_valid/res_count stable, no new en until handshake.
REQ-041 SET_HOST_TIMEOUT_EN, TIMEOUT=16, engine never valid -> res_err=2 at cycle 16 after en; rst mid-RUN -> all outputs at reset values next cycle.
